button_pulse_gen: RTL and testbench

BUTTON_PULSE_GEN -- requirements
Module: button_pulse_gen

---
 rtl/btn_pkg.sv | 26 ++
 rtl/sync2.sv | 21 ++
 rtl/button_pulse_gen.sv | 129 ++++++++++++
 tb/tb_button_pulse_gen.sv | 132 +++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button pulse generator.
package btn_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int REPEAT_DELAY_DEF    = 8;
    localparam int REPEAT_PERIOD_DEF   = 3;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HELD         = 3'd2,
        REPEAT       = 3'd3,
        RELEASE_WAIT = 3'd4
    } btn_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic is_pressed(input btn_state_t s);
        return (s == HELD) || (s == REPEAT) || (s == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_pulse_gen.sv
// Debounces a raw push-button and emits single-cycle strobes on press and during auto-repeat.
//
// state        | meaning
// IDLE         | button released and confirmed
// PRESS_WAIT   | synchronized level high, counting stable press cycles
// HELD         | press confirmed, counting towards auto-repeat
// REPEAT       | auto-repeat active, strobing every REPEAT_PERIOD cycles
// RELEASE_WAIT | synchronized level low, counting stable release cycles
module button_pulse_gen
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic repeat_en,
    output logic pulse,
    output logic pressed
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    generate
        if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
            $error("button_pulse_gen: every timing parameter must be >= 2");
        end
    endgenerate

    logic             btn_s;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_d;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse   <= 1'b0;
            pressed <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse   <= pulse_d;
            pressed <= is_pressed(state_d);
        end
    end

    // Release is tested first in HELD/REPEAT so a coincident terminal count never strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (repeat_en && cnt_q == RD_LAST) begin
                    state_d = REPEAT;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else if (cnt_q != RD_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (!repeat_en) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == RP_LAST) begin
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed-vector bench for button_pulse_gen at default parameters (D=4, RD=8, RP=3).
module tb_button_pulse_gen;

    localparam int N = 48;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_in = 1'b0;
    logic repeat_en = 1'b0;
    logic pulse;
    logic pressed;

    int errors = 0;
    int checks = 0;

    button_pulse_gen dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .repeat_en (repeat_en),
        .pulse     (pulse),
        .pressed   (pressed)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] b(input int k);
        logic [63:0] r;
        r = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clean_reset();
        rst = 1'b0;
        btn_in = 1'b0;
        repeat_en = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        repeat (3) step();
    endtask

    // Vector bit k is the value presented to edge k; traces record outputs just after edge k.
    task automatic run_case(input string tag, input logic [63:0] btn_v, input logic [63:0] ren_v,
                            input logic [63:0] rst_v, input logic [63:0] exp_pulse,
                            input logic [63:0] exp_pressed);
        logic [63:0] pt;
        logic [63:0] pr;
        pt = '0;
        pr = '0;
        clean_reset();
        for (int k = 0; k < N; k++) begin
            btn_in = btn_v[k];
            repeat_en = ren_v[k];
            rst = rst_v[k];
            step();
            pt[k] = pulse;
            pr[k] = pressed;
        end
        check_eq({tag, "_pulse"}, pt, exp_pulse);
        check_eq({tag, "_pressed"}, pr, exp_pressed);
        check_eq({tag, "_no_back2back"}, pt & (pt << 1), 64'd0);
    endtask

    initial begin
        logic [63:0] ones;
        ones = '1;

        #2;
        check_eq("reset_pulse", {63'd0, pulse}, 64'd0);
        check_eq("reset_pressed", {63'd0, pressed}, 64'd0);

        run_case("clean_press", rng(0, 9), ones, ones,
                 b(6), rng(6, 15));

        run_case("bounce", b(0) | b(2), 64'd0, ones,
                 64'd0, 64'd0);

        run_case("repeat", rng(0, 29), ones, ones,
                 b(6) | b(14) | b(17) | b(20) | b(23) | b(26) | b(29), rng(6, 35));

        run_case("repeat_drop", rng(0, 28), rng(0, 15) | rng(20, 47), ones,
                 b(6) | b(14) | b(24) | b(27) | b(30), rng(6, 34));

        run_case("late_enable", rng(0, 24), rng(20, 47), ones,
                 b(6) | b(20) | b(23) | b(26), rng(6, 30));

        run_case("release_glitch", rng(0, 9) | rng(13, 14), 64'd0, ones,
                 b(6), rng(6, 20));

        run_case("reset_mid_press", rng(0, 40), 64'd0, ones & ~rng(5, 8),
                 b(15), rng(15, 46));

        // Asynchronous reset must clear outputs without waiting for a clock edge.
        clean_reset();
        btn_in = 1'b1;
        repeat (7) step();
        check_eq("async_pre_pulse", {63'd0, pulse}, 64'd1);
        check_eq("async_pre_pressed", {63'd0, pressed}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_pulse", {63'd0, pulse}, 64'd0);
        check_eq("async_pressed", {63'd0, pressed}, 64'd0);
        btn_in = 1'b0;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
